carbonio_timer_bank: RTL and testbench

Parametrised timer bank for CarbonIO, generalising the fixed two-timer block to N channels with configurable counter width, per-channel prescaler, one-shot/periodic mode, sticky expiry status and a maskable IRQ aggregate. It sits behind the CarbonIO register decoder, alongside UART and PIO. It drives the timer IRQ sources into the CarbonIO interrupt controller and provides a 64-bit free-running tick counter with a coherent high-word snapshot.

---
 rtl/carbonio_timer_bank_if.sv | 12 +
 rtl/carbonio_timer_bank.sv | 171 +++++++++++++++++
 tb/tb_carbonio_timer_bank.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/carbonio_timer_bank_if.sv
// rtl/carbonio_timer_bank_if.sv - register access bus between the CarbonIO decoder and the timer bank
interface carbonio_timer_bank_if;
    logic        reg_req;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (output reg_req, reg_we, reg_addr, reg_wdata, input reg_rdata, reg_ack);
    modport slave  (input reg_req, reg_we, reg_addr, reg_wdata, output reg_rdata, reg_ack);
endinterface

// File: rtl/carbonio_timer_bank.sv
// rtl/carbonio_timer_bank.sv - N-channel prescaled down-counter timer bank with 64-bit tick counter
module carbonio_timer_bank #(
    parameter int N_TIMERS   = 2,
    parameter int TIMER_W    = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    carbonio_timer_bank_if.slave bus,
    output logic [N_TIMERS-1:0]  expire_pulse,
    output logic [N_TIMERS-1:0]  timer_irq,
    output logic                 irq
);

    logic [TIMER_W-1:0]    load_q  [N_TIMERS];
    logic [TIMER_W-1:0]    load_d  [N_TIMERS];
    logic [TIMER_W-1:0]    value_q [N_TIMERS];
    logic [TIMER_W-1:0]    value_d [N_TIMERS];
    logic [PRESCALE_W-1:0] presc_q [N_TIMERS];
    logic [PRESCALE_W-1:0] presc_d [N_TIMERS];
    logic [PRESCALE_W-1:0] pc_q    [N_TIMERS];
    logic [PRESCALE_W-1:0] pc_d    [N_TIMERS];
    logic [N_TIMERS-1:0]   en_q, en_d, per_q, per_d;
    logic [N_TIMERS-1:0]   pending_q, pending_d, irq_en_q, irq_en_d;
    logic [N_TIMERS-1:0]   pulse_q, pulse_d;
    logic [63:0]           tick_q, tick_d;
    logic [31:0]           snap_q, snap_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ack_q, ack_d;

    logic                  wr, rd, glb;
    logic [N_TIMERS-1:0]   hit_w, tick_w;
    logic                  unused_bits;

    assign wr          = bus.reg_req & bus.reg_we;
    assign rd          = bus.reg_req & ~bus.reg_we;
    assign glb         = (bus.reg_addr[7:4] == 4'h8);
    assign unused_bits = ^{bus.reg_addr[1:0], bus.reg_wdata};

    always_comb begin
        hit_w  = '0;
        tick_w = '0;
        for (int c = 0; c < N_TIMERS; c++) begin
            hit_w[c]  = ~bus.reg_addr[7] && (bus.reg_addr[6:4] == 3'(c));
            tick_w[c] = en_q[c] && (pc_q[c] == presc_q[c]);
        end
    end

    always_comb begin
        pulse_d   = '0;
        en_d      = en_q;
        per_d     = per_q;
        irq_en_d  = irq_en_q;
        pending_d = pending_q;
        tick_d    = tick_q + 64'd1;
        snap_d    = snap_q;
        ack_d     = bus.reg_req;
        for (int c = 0; c < N_TIMERS; c++) begin
            load_d[c]  = load_q[c];
            value_d[c] = value_q[c];
            presc_d[c] = presc_q[c];
            pc_d[c]    = pc_q[c];
            if (en_q[c]) pc_d[c] = tick_w[c] ? '0 : pc_q[c] + 1'b1;
            if (tick_w[c]) begin
                if (value_q[c] != '0) begin
                    value_d[c] = value_q[c] - 1'b1;
                end else begin
                    pulse_d[c] = 1'b1;
                    if (per_q[c]) value_d[c] = load_q[c];
                    else          en_d[c]    = 1'b0;
                end
            end
            // A register write that repositions the counter discards the tick of that cycle
            if (wr && hit_w[c]) begin
                case (bus.reg_addr[3:2])
                    2'd0: load_d[c] = bus.reg_wdata[TIMER_W-1:0];
                    2'd1: begin
                        value_d[c] = bus.reg_wdata[TIMER_W-1:0];
                        pc_d[c]    = '0;
                        pulse_d[c] = 1'b0;
                        en_d[c]    = en_q[c];
                    end
                    2'd2: begin
                        en_d[c]    = bus.reg_wdata[0];
                        per_d[c]   = bus.reg_wdata[1];
                        presc_d[c] = bus.reg_wdata[8 +: PRESCALE_W];
                        if ((bus.reg_wdata[0] && !en_q[c]) || bus.reg_wdata[2]) begin
                            value_d[c] = load_q[c];
                            pc_d[c]    = '0;
                            pulse_d[c] = 1'b0;
                        end else if (!bus.reg_wdata[0]) begin
                            value_d[c] = value_q[c];
                            pc_d[c]    = '0;
                            pulse_d[c] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        if (wr && glb && bus.reg_addr[3:2] == 2'd2) pending_d = pending_q & ~bus.reg_wdata[N_TIMERS-1:0];
        if (wr && glb && bus.reg_addr[3:2] == 2'd3) irq_en_d  = bus.reg_wdata[N_TIMERS-1:0];
        pending_d = pending_d | pulse_d;
        if (rd && glb && bus.reg_addr[3:2] == 2'd0) snap_d = tick_q[63:32];
    end

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            for (int c = 0; c < N_TIMERS; c++) begin
                if (hit_w[c]) begin
                    case (bus.reg_addr[3:2])
                        2'd0:    rdata_d = 32'(load_q[c]);
                        2'd1:    rdata_d = 32'(value_q[c]);
                        2'd2:    rdata_d = {16'b0, 8'(presc_q[c]), 6'b0, per_q[c], en_q[c]};
                        default: rdata_d = {30'b0, en_q[c], pending_q[c]};
                    endcase
                end
            end
            if (glb) begin
                case (bus.reg_addr[3:2])
                    2'd0:    rdata_d = tick_q[31:0];
                    2'd1:    rdata_d = snap_q;
                    2'd2:    rdata_d = 32'(pending_q);
                    default: rdata_d = 32'(irq_en_q);
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_TIMERS; c++) begin
                load_q[c]  <= '0;
                value_q[c] <= '0;
                presc_q[c] <= '0;
                pc_q[c]    <= '0;
            end
            en_q      <= '0;
            per_q     <= '0;
            pending_q <= '0;
            irq_en_q  <= '0;
            pulse_q   <= '0;
            tick_q    <= '0;
            snap_q    <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
        end else begin
            load_q    <= load_d;
            value_q   <= value_d;
            presc_q   <= presc_d;
            pc_q      <= pc_d;
            en_q      <= en_d;
            per_q     <= per_d;
            pending_q <= pending_d;
            irq_en_q  <= irq_en_d;
            pulse_q   <= pulse_d;
            tick_q    <= tick_d;
            snap_q    <= snap_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
        end
    end

    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;
    assign expire_pulse  = pulse_q;
    assign timer_irq     = pending_q & irq_en_q;
    assign irq           = |timer_irq;

endmodule

// File: tb/tb_carbonio_timer_bank.sv
// tb/tb_carbonio_timer_bank.sv - self-checking bench for carbonio_timer_bank against a schedule model
module tb_carbonio_timer_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] expire_pulse, timer_irq;
    logic       irq;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         log0[$];
    int         log1[$];

    carbonio_timer_bank_if bus ();

    carbonio_timer_bank #(.N_TIMERS(2), .TIMER_W(32), .PRESCALE_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .expire_pulse (expire_pulse),
        .timer_irq    (timer_irq),
        .irq          (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse from edge n is logged with index n at edge n+1
    always @(posedge clk) begin
        if (expire_pulse[0]) log0.push_back(cyc);
        if (expire_pulse[1]) log1.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        bus.reg_req = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
        @(negedge clk);
        bus.reg_req = 1'b0; bus.reg_we = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        bus.reg_req = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = a;
        @(negedge clk);
        bus.reg_req = 1'b0;
        d = bus.reg_rdata;
        chk("ack", {63'b0, bus.reg_ack}, 64'd1);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Expected expiries: edge + k*period, k >= 1, only the first in one-shot mode
    task automatic cmp_sched(input string tag, input int lg[$], input int from, input int period,
                             input bit periodic, input int last);
        int exp_q[$];
        int got_q[$];
        for (int t = from + period; t <= last; t += period) begin
            exp_q.push_back(t);
            if (!periodic) break;
        end
        foreach (lg[i]) if (lg[i] > from) got_q.push_back(lg[i]);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk(tag, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        logic [31:0] d, lo, hi;
        logic [63:0] v, prev, f;
        int rel, e, e0, e1, w, got_q[$];
        int l0, l1, p0, p1, ien;
        bit per0, per1;

        bus.reg_req = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", {63'b0, bus.reg_ack}, 64'd0);
        chk("rst_rdata", 64'(bus.reg_rdata), 64'd0);
        chk("rst_pulse", 64'(expire_pulse), 64'd0);
        chk("rst_tirq", 64'(timer_irq), 64'd0);
        chk("rst_irq", {63'b0, irq}, 64'd0);
        rst_n = 1'b1;
        rel = cyc;
        bus_rd(8'h84, d); chk("tick_hi_init", 64'(d), 64'd0);
        e = cyc - rel;
        bus_rd(8'h80, d); chk("tick_lo", 64'(d), 64'(e));
        bus_rd(8'h84, d); chk("tick_hi", 64'(d), 64'd0);
        bus_rd(8'h08, d); chk("rst_ctrl0", 64'(d), 64'd0);
        bus_rd(8'h8C, d); chk("rst_ien", 64'(d), 64'd0);

        // One-shot
        bus_wr(8'h00, 32'd3);
        e = cyc + 1;
        bus_wr(8'h08, 32'h1);
        wait_until(e + 30);
        cmp_sched("oneshot", log0, e, 4, 1'b0, cyc - 1);
        bus_rd(8'h08, d); chk("os_ctrl", 64'(d), 64'd0);
        bus_rd(8'h04, d); chk("os_value", 64'(d), 64'd0);
        bus_rd(8'h0C, d); chk("os_status", 64'(d), 64'd1);
        repeat (20) @(negedge clk);
        cmp_sched("oneshot_quiet", log0, e, 4, 1'b0, cyc - 1);
        bus_wr(8'h88, 32'h1);

        // Periodic with prescaler, W1C and set-wins
        bus_wr(8'h00, 32'd2);
        e = cyc + 1;
        bus_wr(8'h08, 32'h103);
        bus_wr(8'h8C, 32'h1);
        wait_until(e + 20);
        cmp_sched("periodic", log0, e, 6, 1'b1, cyc - 1);
        chk("per_irq", {63'b0, irq}, 64'd1);
        chk("per_tirq", 64'(timer_irq), 64'd1);
        bus_wr(8'h88, 32'h1);
        chk("w1c_irq", {63'b0, irq}, 64'd0);
        wait_until(e + 23);
        bus_wr(8'h88, 32'h1);
        chk("setwins_irq", {63'b0, irq}, 64'd1);
        bus_rd(8'h88, d); chk("setwins_pend", 64'(d), 64'd1);
        bus_wr(8'h08, 32'h0);
        bus_wr(8'h88, 32'h1);
        chk("stop_irq", {63'b0, irq}, 64'd0);

        // VALUE write mid-count
        bus_wr(8'h00, 32'd2);
        bus_wr(8'h08, 32'h3);
        repeat (5) @(negedge clk);
        w = cyc + 1;
        bus_wr(8'h04, 32'd10);
        wait_until(w + 20);
        got_q.delete();
        foreach (log0[i]) if (log0[i] >= w) got_q.push_back(log0[i]);
        chk("valwr_count", {63'b0, got_q.size() >= 2}, 64'd1);
        if (got_q.size() >= 2) begin
            chk("valwr_first", 64'(got_q[0]), 64'(w + 11));
            chk("valwr_second", 64'(got_q[1]), 64'(w + 14));
        end
        bus_wr(8'h08, 32'h0);
        bus_wr(8'h88, 32'h3);

        // Randomized channel configurations against the expiry schedule model
        for (int it = 0; it < 6; it++) begin
            l0 = $urandom_range(0, 9); p0 = $urandom_range(0, 3); per0 = 1'($urandom_range(0, 1));
            l1 = $urandom_range(0, 9); p1 = $urandom_range(0, 3); per1 = 1'($urandom_range(0, 1));
            bus_wr(8'h00, 32'(l0));
            bus_wr(8'h10, 32'(l1));
            e0 = cyc + 1;
            bus_wr(8'h08, 32'((p0 << 8) | (int'(per0) << 1) | 1));
            e1 = cyc + 1;
            bus_wr(8'h18, 32'((p1 << 8) | (int'(per1) << 1) | 1));
            ien = $urandom_range(0, 3);
            bus_wr(8'h8C, 32'(ien));
            wait_until(e0 + 70);
            cmp_sched("rand_ch0", log0, e0, (l0 + 1) * (p0 + 1), per0, cyc - 1);
            cmp_sched("rand_ch1", log1, e1, (l1 + 1) * (p1 + 1), per1, cyc - 1);
            chk("rand_tirq", 64'(timer_irq), 64'(ien));
            chk("rand_irq", {63'b0, irq}, {63'b0, ien != 0});
            bus_rd(8'h0C, d); chk("rand_status0", 64'(d), per0 ? 64'd3 : 64'd1);
            bus_rd(8'h18, d); chk("rand_ctrl1", 64'(d), 64'((p1 << 8) | (per1 ? 3 : 0)));
            bus_rd(8'h10, d); chk("rand_load1", 64'(d), 64'(l1));
            bus_rd(8'h88, d); chk("rand_pend", 64'(d), 64'd3);
            bus_wr(8'h08, 32'h0);
            bus_wr(8'h18, 32'h0);
            bus_wr(8'h88, 32'h3);
            chk("rand_clr_irq", {63'b0, irq}, 64'd0);
        end

        // Unmapped channel and offsets
        bus_wr(8'h00, 32'h55);
        bus_wr(8'h20, 32'hDEAD);
        bus_wr(8'h28, 32'h1);
        bus_rd(8'h20, d); chk("unmap_20", 64'(d), 64'd0);
        bus_rd(8'h00, d); chk("unmap_load0", 64'(d), 64'h55);
        bus_rd(8'h28, d); chk("unmap_28", 64'(d), 64'd0);
        bus_rd(8'h90, d); chk("unmap_90", 64'(d), 64'd0);

        // Tick snapshot coherence across the low-word wrap
        f = 64'h0000_0000_FFFF_FFF0;
        force dut.tick_q = f;
        @(negedge clk);
        release dut.tick_q;
        prev = '0;
        for (int i = 0; i < 12; i++) begin
            bus_rd(8'h80, lo);
            bus_rd(8'h84, hi);
            v = {hi, lo};
            chk("tick_window", {63'b0, (v >= f) && (v < f + 64)}, 64'd1);
            chk("tick_mono", {63'b0, v > prev}, 64'd1);
            prev = v;
        end
        chk("tick_wrapped", 64'(hi), 64'd1);

        // Reset mid-count
        bus_wr(8'h00, 32'd1);
        bus_wr(8'h08, 32'h3);
        bus_wr(8'h8C, 32'h1);
        repeat (6) @(negedge clk);
        chk("pre_rst_irq", {63'b0, irq}, 64'd1);
        rst_n = 1'b0;
        bus.reg_req = 1'b1; bus.reg_we = 1'b0; bus.reg_addr = 8'h0C;
        @(negedge clk);
        bus.reg_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_pulse", 64'(expire_pulse), 64'd0);
            chk("midrst_tirq", 64'(timer_irq), 64'd0);
            chk("midrst_irq", {63'b0, irq}, 64'd0);
            chk("midrst_ack", {63'b0, bus.reg_ack}, 64'd0);
            chk("midrst_rdata", 64'(bus.reg_rdata), 64'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        bus_rd(8'h08, d); chk("post_rst_ctrl", 64'(d), 64'd0);
        bus_rd(8'h00, d); chk("post_rst_load", 64'(d), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
